// File: rtl/tag_issuer.sv
// tag_issuer: hands tags 0..NUM_COL-1 to the PE columns one at a time, waiting for each to lock.
// Optional feature macro TAG_ISSUER_TIMEOUT_EN adds a per-column WAIT timeout with a sticky ERR state.
module tag_issuer #(
    parameter  int NUM_COL     = 4,
    parameter  int TIMEOUT_CYC = 16,
    localparam int TAG_W       = $clog2(NUM_COL)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [NUM_COL-1:0] lock_i,
    output logic [NUM_COL-1:0] flush_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NUM_COL - 1);

`ifdef TAG_ISSUER_TIMEOUT_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             err_r;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;
`endif

    state_t             state_r;
    state_t             state_s;
    logic [TAG_W-1:0]   idx_r;
    logic [TAG_W-1:0]   idx_s;
    logic [NUM_COL-1:0] flush_s;
    logic [TAG_W-1:0]   tag_s;
    logic [NUM_COL-1:0] flush_r;
    logic [TAG_W-1:0]   tag_r;
    logic               busy_r;
    logic               done_r;

    // Next-state, column index and timeout counter; abort overrides everything else.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
`ifdef TAG_ISSUER_TIMEOUT_EN
        cnt_s   = cnt_r;
`endif
        if (abort) begin
            state_s = IDLE;
            idx_s   = {TAG_W{1'b0}};
`ifdef TAG_ISSUER_TIMEOUT_EN
            cnt_s   = {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_s = ISSUE;
                        idx_s   = {TAG_W{1'b0}};
                    end else begin
                        state_s = IDLE;
                    end
                end
                ISSUE: begin
                    state_s = WAIT;
`ifdef TAG_ISSUER_TIMEOUT_EN
                    cnt_s   = {CNT_W{1'b0}};
`endif
                end
                WAIT: begin
                    // Only the addressed column's lock bit matters.
                    if (lock_i[idx_r]) begin
                        if (idx_r == LAST_IDX) begin
                            state_s = DONE;
                            idx_s   = {TAG_W{1'b0}};
                        end else begin
                            state_s = ISSUE;
                            idx_s   = idx_r + TAG_W'(1'b1);
                        end
                    end else begin
`ifdef TAG_ISSUER_TIMEOUT_EN
                        if (cnt_r == CNT_LAST) begin
                            state_s = ERR;
                        end else begin
                            cnt_s   = cnt_r + CNT_W'(1'b1);
                        end
`else
                        state_s = WAIT;
`endif
                    end
                end
                DONE: begin
                    state_s = IDLE;
                end
`ifdef TAG_ISSUER_TIMEOUT_EN
                ERR: begin
                    state_s = ERR;
                end
`endif
                default: begin
                    state_s = IDLE;
                    idx_s   = {TAG_W{1'b0}};
                end
            endcase
        end
    end

    // Flush strobe and tag for the state being entered, so they can be registered.
    always_comb begin
        flush_s = {NUM_COL{1'b0}};
        tag_s   = {TAG_W{1'b0}};
        if (state_s == ISSUE) begin
            flush_s = NUM_COL'(1'b1) << idx_s;
            tag_s   = idx_s;
        end else begin
            flush_s = {NUM_COL{1'b0}};
            tag_s   = {TAG_W{1'b0}};
        end
    end

    // State, index and output registers; outputs mirror the registered state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            idx_r   <= {TAG_W{1'b0}};
            flush_r <= {NUM_COL{1'b0}};
            tag_r   <= {TAG_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            flush_r <= flush_s;
            tag_r   <= tag_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

`ifdef TAG_ISSUER_TIMEOUT_EN
    // Timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= {CNT_W{1'b0}};
            err_r <= 1'b0;
        end else begin
            cnt_r <= cnt_s;
            err_r <= (state_s == ERR);
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign flush_o = flush_r;
    assign tag_o   = tag_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_tag_issuer.sv
// Self-checking bench for tag_issuer: a scoreboard of expected flush/tag issues plus per-scenario
// cycle-accurate checks against a small timing model of the issue/wait handshake.
module tb_tag_issuer;

    localparam int NUM_COL     = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int MAXC        = 64;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       abort;
    logic [3:0] lock_i;
    logic [3:0] flush_o;
    logic [1:0] tag_o;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] flush;
        logic [1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;
    int   flush_seen = 0;
    int   done_seen  = 0;

    int              cfg_d[NUM_COL];
    logic [3:0]      cfg_force;
    logic [MAXC-1:0] cfg_start;
    int              cfg_abort;
    int              cfg_ncyc;

    logic [3:0] obs_flush[MAXC];
    logic [1:0] obs_tag[MAXC];
    logic       obs_busy[MAXC];
    logic       obs_done[MAXC];
    logic       obs_err[MAXC];
    logic [3:0] exp_flush[MAXC];
    logic [1:0] exp_tag[MAXC];
    logic       exp_busy[MAXC];
    logic       exp_done[MAXC];
    int         exp_f[NUM_COL];
    int         exp_done_cyc;

    tag_issuer #(
        .NUM_COL     (NUM_COL),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .abort   (abort),
        .lock_i  (lock_i),
        .flush_o (flush_o),
        .tag_o   (tag_o),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every flush strobe must match the next expected issue, in order.
    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (flush_o !== 4'b0000) begin
            flush_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: flush_o=%b tag_o=%0d, no issue expected", flush_o, tag_o);
            end else begin
                sb_e = exp_q.pop_front();
                if (flush_o !== sb_e.flush || tag_o !== sb_e.tag) begin
                    errors++;
                    $display("FAIL sb_issue: flush_o=%b tag_o=%0d, want %b/%0d", flush_o, tag_o, sb_e.flush, sb_e.tag);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Builds the expected timeline, pushes expected issues, then drives start/abort and a lock responder.
    task automatic run_seq();
        int         obs_f[NUM_COL];
        int         eff;
        int         last;
        logic [3:0] lk;
        exp_t       e;
        exp_f[0] = 1;
        for (int k = 1; k < NUM_COL; k++) begin
            eff = cfg_force[k-1] ? 1 : cfg_d[k-1];
            exp_f[k] = exp_f[k-1] + eff + 1;
        end
        eff = cfg_force[NUM_COL-1] ? 1 : cfg_d[NUM_COL-1];
        exp_done_cyc = exp_f[NUM_COL-1] + eff + 1;
        last = (cfg_abort > 0) ? cfg_abort : exp_done_cyc;
        for (int c = 0; c < MAXC; c++) begin
            exp_flush[c] = 4'b0000;
            exp_tag[c]   = 2'd0;
            exp_busy[c]  = (c >= 1 && c <= last);
            exp_done[c]  = (cfg_abort == 0 && c == exp_done_cyc);
        end
        for (int k = 0; k < NUM_COL; k++) begin
            obs_f[k] = -1;
            if (exp_f[k] <= last) begin
                exp_flush[exp_f[k]] = 4'b0001 << k;
                exp_tag[exp_f[k]]   = 2'(k);
                e.flush = 4'b0001 << k;
                e.tag   = 2'(k);
                exp_q.push_back(e);
            end
        end
        start  = 1'b1;
        abort  = 1'b0;
        lock_i = cfg_force;
        for (int c = 0; c <= cfg_ncyc; c++) begin
            if (c > 0) begin
                tick();
                start = cfg_start[c];
                abort = (c == cfg_abort);
                lk = cfg_force;
                for (int k = 0; k < NUM_COL; k++)
                    if (obs_f[k] >= 0 && c >= obs_f[k] + cfg_d[k]) lk[k] = 1'b1;
                lock_i = lk;
            end
            @(negedge clk);
            obs_flush[c] = flush_o;
            obs_tag[c]   = tag_o;
            obs_busy[c]  = busy;
            obs_done[c]  = done;
            obs_err[c]   = err;
            for (int k = 0; k < NUM_COL; k++)
                if (flush_o[k] === 1'b1 && obs_f[k] < 0) obs_f[k] = c;
        end
        tick();
        start  = 1'b0;
        abort  = 1'b0;
        lock_i = 4'b0000;
    endtask

    task automatic set_cfg(input int d2, input logic [3:0] frc, input int abort_cyc, input int ncyc);
        cfg_d[0]  = 1;
        cfg_d[1]  = 1;
        cfg_d[2]  = d2;
        cfg_d[3]  = 1;
        cfg_force = frc;
        cfg_start = {MAXC{1'b0}};
        cfg_abort = abort_cyc;
        cfg_ncyc  = ncyc;
    endtask

    task automatic test_reset();
        rstn   = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        lock_i = 4'b0000;
        #12;
        checks++; if (flush_o !== 4'b0000) begin errors++; $display("FAIL reset_flush: got %b want 0000", flush_o); end
        checks++; if (tag_o !== 2'd0) begin errors++; $display("FAIL reset_tag: got %0d want 0", tag_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        @(negedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || flush_o !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle: busy=%b flush=%b want 0/0000", busy, flush_o);
            end
        end
        tick();
    endtask

    task automatic test_sequence();
        set_cfg(1, 4'b0000, 0, 12);
        run_seq();
        for (int c = 0; c <= cfg_ncyc; c++) begin
            checks++;
            if (obs_flush[c] !== exp_flush[c] || obs_tag[c] !== exp_tag[c] ||
                obs_busy[c] !== exp_busy[c] || obs_done[c] !== exp_done[c]) begin
                errors++;
                $display("FAIL seq_cycle%0d: flush=%b tag=%0d busy=%b done=%b want %b/%0d/%b/%b", c,
                         obs_flush[c], obs_tag[c], obs_busy[c], obs_done[c],
                         exp_flush[c], exp_tag[c], exp_busy[c], exp_done[c]);
            end
        end
        checks++; if (obs_flush[1] !== 4'b0001 || obs_tag[1] !== 2'd0) begin errors++; $display("FAIL seq_c1: got %b/%0d want 0001/0", obs_flush[1], obs_tag[1]); end
        checks++; if (obs_flush[7] !== 4'b1000 || obs_tag[7] !== 2'd3) begin errors++; $display("FAIL seq_c7: got %b/%0d want 1000/3", obs_flush[7], obs_tag[7]); end
        checks++; if (obs_done[9] !== 1'b1) begin errors++; $display("FAIL seq_done9: got %b want 1", obs_done[9]); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL seq_sb_left: %0d issues missing, want 0", exp_q.size()); end
    endtask

    task automatic test_late_lock();
        set_cfg(5, 4'b1000, 0, 16);
        run_seq();
        for (int c = 0; c <= cfg_ncyc; c++) begin
            checks++;
            if (obs_flush[c] !== exp_flush[c] || obs_tag[c] !== exp_tag[c] ||
                obs_busy[c] !== exp_busy[c] || obs_done[c] !== exp_done[c]) begin
                errors++;
                $display("FAIL late_cycle%0d: flush=%b tag=%0d busy=%b done=%b want %b/%0d/%b/%b", c,
                         obs_flush[c], obs_tag[c], obs_busy[c], obs_done[c],
                         exp_flush[c], exp_tag[c], exp_busy[c], exp_done[c]);
            end
        end
        checks++; if (obs_flush[11] !== 4'b1000) begin errors++; $display("FAIL late_flush3: got %b at cycle 11 want 1000", obs_flush[11]); end
        checks++; if (obs_done[13] !== 1'b1) begin errors++; $display("FAIL late_done13: got %b want 1", obs_done[13]); end
    endtask

    task automatic test_restart_ignored();
        int d0;
        int f0;
        set_cfg(1, 4'b0000, 0, 14);
        cfg_start[2] = 1'b1;
        cfg_start[4] = 1'b1;
        cfg_start[9] = 1'b1;
        d0 = done_seen;
        f0 = flush_seen;
        run_seq();
        for (int c = 0; c <= cfg_ncyc; c++) begin
            checks++;
            if (obs_flush[c] !== exp_flush[c] || obs_busy[c] !== exp_busy[c] || obs_done[c] !== exp_done[c]) begin
                errors++;
                $display("FAIL restart_cycle%0d: flush=%b busy=%b done=%b want %b/%b/%b", c,
                         obs_flush[c], obs_busy[c], obs_done[c], exp_flush[c], exp_busy[c], exp_done[c]);
            end
        end
        checks++; if (done_seen - d0 != 1) begin errors++; $display("FAIL restart_done_cnt: got %0d want 1", done_seen - d0); end
        checks++; if (flush_seen - f0 != 4) begin errors++; $display("FAIL restart_flush_cnt: got %0d want 4", flush_seen - f0); end
    endtask

    task automatic test_abort();
        int d0;
        int f0;
        set_cfg(1, 4'b0000, 6, 10);
        cfg_start[6] = 1'b1;
        d0 = done_seen;
        f0 = flush_seen;
        run_seq();
        for (int c = 0; c <= cfg_ncyc; c++) begin
            checks++;
            if (obs_flush[c] !== exp_flush[c] || obs_busy[c] !== exp_busy[c] || obs_done[c] !== exp_done[c]) begin
                errors++;
                $display("FAIL abort_cycle%0d: flush=%b busy=%b done=%b want %b/%b/%b", c,
                         obs_flush[c], obs_busy[c], obs_done[c], exp_flush[c], exp_busy[c], exp_done[c]);
            end
        end
        checks++; if (obs_busy[7] !== 1'b0) begin errors++; $display("FAIL abort_busy7: got %b want 0", obs_busy[7]); end
        checks++; if (done_seen != d0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen - d0); end
        checks++; if (flush_seen - f0 != 3) begin errors++; $display("FAIL abort_flush_cnt: got %0d want 3", flush_seen - f0); end
        set_cfg(1, 4'b0000, 0, 10);
        run_seq();
        checks++; if (obs_flush[1] !== 4'b0001 || obs_tag[1] !== 2'd0) begin errors++; $display("FAIL abort_reissue: got %b/%0d want 0001/0", obs_flush[1], obs_tag[1]); end
        checks++; if (obs_done[9] !== 1'b1) begin errors++; $display("FAIL abort_reissue_done: got %b want 1", obs_done[9]); end
    endtask

    task automatic test_wait_timeout();
        logic exp_err;
        set_cfg(1, 4'b0000, 22, 25);
        cfg_d[0] = 100;
        cfg_start[20] = 1'b1;
        run_seq();
        for (int c = 0; c <= cfg_ncyc; c++) begin
`ifdef TAG_ISSUER_TIMEOUT_EN
            exp_err = (c >= 2 + TIMEOUT_CYC && c <= 22);
`else
            exp_err = 1'b0;
`endif
            checks++;
            if (obs_flush[c] !== exp_flush[c] || obs_busy[c] !== exp_busy[c] ||
                obs_done[c] !== exp_done[c] || obs_err[c] !== exp_err) begin
                errors++;
                $display("FAIL tmo_cycle%0d: flush=%b busy=%b done=%b err=%b want %b/%b/%b/%b", c,
                         obs_flush[c], obs_busy[c], obs_done[c], obs_err[c],
                         exp_flush[c], exp_busy[c], exp_done[c], exp_err);
            end
        end
        checks++; if (obs_busy[21] !== 1'b1 || obs_flush[21] !== 4'b0000) begin errors++; $display("FAIL tmo_start_ignored: busy=%b flush=%b want 1/0000", obs_busy[21], obs_flush[21]); end
        checks++; if (obs_busy[23] !== 1'b0 || obs_err[23] !== 1'b0) begin errors++; $display("FAIL tmo_abort_clear: busy=%b err=%b want 0/0", obs_busy[23], obs_err[23]); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        e.flush = 4'b0001; e.tag = 2'd0; exp_q.push_back(e);
        e.flush = 4'b0010; e.tag = 2'd1; exp_q.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        lock_i = 4'b0001;
        tick();
        @(negedge clk);
        checks++; if (flush_o !== 4'b0010) begin errors++; $display("FAIL rmid_issue1: got %b want 0010", flush_o); end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (flush_o !== 4'b0000 || tag_o !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: flush=%b tag=%0d busy=%b done=%b err=%b want all 0", flush_o, tag_o, busy, done, err);
        end
        lock_i = 4'b0000;
        tick();
        @(negedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            lock_i = 4'b1111;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || flush_o !== 4'b0000 || done !== 1'b0) begin
                errors++;
                $display("FAIL rmid_idle: busy=%b flush=%b done=%b want 0/0000/0", busy, flush_o, done);
            end
        end
        lock_i = 4'b0000;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_sb_left: %0d issues missing, want 0", exp_q.size()); end
        tick();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_late_lock();
        test_restart_ignored();
        test_abort();
        test_wait_timeout();
        test_reset_mid();
        test_sequence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
